// File: rtl/utopia_pkg.sv
// Shared types and constants for the UTOPIA level-1 receive path: the cell layout,
// the receive FSM encoding and the HEC CRC-8 step used when header checking is built in.
package utopia_pkg;

  localparam int CELL_BYTES    = 53;
  localparam int HDR_BYTES     = 5;
  localparam int PAYLOAD_BYTES = 48;
  localparam int CELL_W        = 424;

  localparam logic [7:0] HEC_POLY  = 8'h07;
  localparam logic [7:0] HEC_COSET = 8'h55;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_HDR,
    RX_PAYLOAD,
    RX_COMMIT
  } rx_state_e;

  // Payload byte k occupies bits [8k+7:8k] of the payload field.
  typedef struct packed {
    logic [3:0]                    gfc;
    logic [7:0]                    vpi;
    logic [15:0]                   vci;
    logic                          clp;
    logic [2:0]                    pt;
    logic [7:0]                    hec;
    logic [PAYLOAD_BYTES-1:0][7:0] payload;
  } cell_t;

  typedef struct packed {
    rx_state_e  state;
    logic [5:0] cnt;
  } rx_ctl_t;

  function automatic logic [7:0] hec_crc_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ HEC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/utopia_cell_fifo.sv
// First-word-fall-through cell FIFO; the head entry is held in an output register so
// rd_data comes straight from a flop. A write into a full FIFO is taken only alongside a pop.
module utopia_cell_fifo #(
  parameter int WIDTH = 424,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_ready,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push, pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign occupancy = count_q;
  assign rd_data   = head_q;

  always_comb begin
    pop      = rd_ready && !empty;
    push     = wr_en && (!full || pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    head_d   = head_q;
    // The new head is either an older stored entry or the cell being written this cycle.
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        head_d = wr_data;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/utopia1_atm_rx.sv
// UTOPIA level-1 ATM receiver: reassembles 53-byte cells from the link into a cell FIFO.
// Define UTOPIA_RX_HEC_CHECK_EN to drop cells whose HEC byte fails the CRC-8 check.
module utopia1_atm_rx #(
  parameter int CELL_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         soc,
  input  logic [7:0]   data,
  input  logic         en,
  output logic         clav,
  output logic         rx_valid,
  input  logic         rx_ready,
  output logic [3:0]   uni_GFC,
  output logic [7:0]   uni_VPI,
  output logic [15:0]  uni_VCI,
  output logic         uni_CLP,
  output logic [2:0]   uni_PT,
  output logic [7:0]   uni_HEC,
  output logic [383:0] uni_Payload,
  output logic         fifo_full,
  output logic         runt_err,
  output logic         hec_err
);

  import utopia_pkg::*;

  localparam int OW = $clog2(CELL_DEPTH) + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(CELL_DEPTH);

  // Handshake: a cell transfers on every rising edge where rx_valid && rx_ready; while
  // rx_valid && !rx_ready the uni_* outputs hold, and rx_valid never drops without a transfer.
  rx_ctl_t           ctl_q, ctl_d;
  cell_t             stage_q, stage_d;
  cell_t             b0_cell, rd_cell;
  logic              clav_q, clav_d;
  logic              runt_q, runt_d;
  logic              start, pop, wr_ok, wr_en;
  logic              fifo_empty, fifo_full_int;
  logic [OW-1:0]     fifo_occ;
  logic [CELL_W-1:0] rd_data;

`ifdef UTOPIA_RX_HEC_CHECK_EN
  logic [7:0] crc_q, crc_d;
  logic       hec_q, hec_d;
`endif

  assign pop   = rx_ready && !fifo_empty;
  assign wr_ok = !fifo_full_int || pop;

  always_comb begin
    b0_cell     = '0;
    b0_cell.gfc = data[7:4];
    b0_cell.vpi = {data[3:0], 4'h0};
  end

  always_comb begin
    ctl_d   = ctl_q;
    stage_d = stage_q;
`ifdef UTOPIA_RX_HEC_CHECK_EN
    crc_d   = crc_q;
    hec_d   = 1'b0;
`endif
    // A new cell can begin anywhere except in a COMMIT that cannot write yet.
    start  = en && soc && ((ctl_q.state != RX_COMMIT) || wr_ok);
    runt_d = en && soc && ((ctl_q.state == RX_HDR) || (ctl_q.state == RX_PAYLOAD));
    wr_en  = (ctl_q.state == RX_COMMIT) && wr_ok;

    case (ctl_q.state)
      RX_HDR: begin
        if (en && !soc) begin
          case (ctl_q.cnt[2:0])
            3'd1: begin
              stage_d.vpi[3:0]   = data[7:4];
              stage_d.vci[15:12] = data[3:0];
            end
            3'd2: stage_d.vci[11:4] = data;
            3'd3: begin
              stage_d.vci[3:0] = data[7:4];
              stage_d.clp      = data[3];
              stage_d.pt       = data[2:0];
            end
            default: stage_d.hec = data;
          endcase
          if (ctl_q.cnt == 6'd4) begin
            ctl_d = '{state: RX_PAYLOAD, cnt: 6'd0};
`ifdef UTOPIA_RX_HEC_CHECK_EN
            if (data != (crc_q ^ HEC_COSET)) begin
              ctl_d = '{state: RX_IDLE, cnt: 6'd0};
              hec_d = 1'b1;
            end
`endif
          end else begin
            ctl_d.cnt = ctl_q.cnt + 6'd1;
`ifdef UTOPIA_RX_HEC_CHECK_EN
            crc_d = hec_crc_step(crc_q, data);
`endif
          end
        end
      end
      RX_PAYLOAD: begin
        if (en && !soc) begin
          stage_d.payload[ctl_q.cnt] = data;
          if (ctl_q.cnt == 6'(PAYLOAD_BYTES - 1)) begin
            ctl_d = '{state: RX_COMMIT, cnt: 6'd0};
          end else begin
            ctl_d.cnt = ctl_q.cnt + 6'd1;
          end
        end
      end
      RX_COMMIT: begin
        if (wr_ok) begin
          ctl_d = '{state: RX_IDLE, cnt: 6'd0};
        end
      end
      default: ;
    endcase

    if (start) begin
      stage_d = b0_cell;
      ctl_d   = '{state: RX_HDR, cnt: 6'd1};
`ifdef UTOPIA_RX_HEC_CHECK_EN
      crc_d   = hec_crc_step(8'h00, data);
`endif
    end

    clav_d = !(fifo_full_int || (ctl_d.state == RX_COMMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q   <= '{state: RX_IDLE, cnt: 6'd0};
      stage_q <= '0;
      clav_q  <= 1'b0;
      runt_q  <= 1'b0;
`ifdef UTOPIA_RX_HEC_CHECK_EN
      crc_q   <= 8'h00;
      hec_q   <= 1'b0;
`endif
    end else begin
      ctl_q   <= ctl_d;
      stage_q <= stage_d;
      clav_q  <= clav_d;
      runt_q  <= runt_d;
`ifdef UTOPIA_RX_HEC_CHECK_EN
      crc_q   <= crc_d;
      hec_q   <= hec_d;
`endif
    end
  end

  utopia_cell_fifo #(
    .WIDTH (CELL_W),
    .DEPTH (CELL_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (stage_q),
    .rd_ready  (rx_ready),
    .rd_data   (rd_data),
    .empty     (fifo_empty),
    .full      (fifo_full_int),
    .occupancy (fifo_occ)
  );

  assign rd_cell     = cell_t'(rd_data);
  assign rx_valid    = !fifo_empty;
  assign fifo_full   = (fifo_occ == OCC_FULL);
  assign clav        = clav_q;
  assign runt_err    = runt_q;
  assign uni_GFC     = rd_cell.gfc;
  assign uni_VPI     = rd_cell.vpi;
  assign uni_VCI     = rd_cell.vci;
  assign uni_CLP     = rd_cell.clp;
  assign uni_PT      = rd_cell.pt;
  assign uni_HEC     = rd_cell.hec;
  assign uni_Payload = rd_cell.payload;

`ifdef UTOPIA_RX_HEC_CHECK_EN
  assign hec_err = hec_q;
`else
  assign hec_err = 1'b0;
`endif

endmodule

// File: tb/tb_utopia1_atm_rx.sv
// Self-checking bench for utopia1_atm_rx: directed scenarios plus randomized cells,
// with a byte-level reference model feeding an in-order scoreboard.
module tb_utopia1_atm_rx;

  localparam int CELL_DEPTH = 4;
`ifdef UTOPIA_RX_HEC_CHECK_EN
  localparam bit HEC_CHK = 1'b1;
`else
  localparam bit HEC_CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         soc = 1'b0;
  logic [7:0]   data = 8'h00;
  logic         en = 1'b0;
  logic         rx_ready = 1'b0;
  logic         clav, rx_valid, uni_CLP, fifo_full, runt_err, hec_err;
  logic [3:0]   uni_GFC;
  logic [7:0]   uni_VPI, uni_HEC;
  logic [15:0]  uni_VCI;
  logic [2:0]   uni_PT;
  logic [383:0] uni_Payload;

  utopia1_atm_rx #(.CELL_DEPTH(CELL_DEPTH)) dut (
    .clk(clk), .rst(rst), .soc(soc), .data(data), .en(en), .clav(clav),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .uni_GFC(uni_GFC), .uni_VPI(uni_VPI), .uni_VCI(uni_VCI), .uni_CLP(uni_CLP),
    .uni_PT(uni_PT), .uni_HEC(uni_HEC), .uni_Payload(uni_Payload),
    .fifo_full(fifo_full), .runt_err(runt_err), .hec_err(hec_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [423:0] exp_q[$];
  logic [7:0]   cell_b [0:52];
  int ready_mode = 0;
  int runt_seen = 0;
  int hec_seen = 0;
  int hec_exp = 0;

  task automatic check(input string name, input logic [423:0] act, input logic [423:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_crc();
    logic [31:0] bits;
    logic [7:0]  c;
    logic        fb;
    bits = {cell_b[0], cell_b[1], cell_b[2], cell_b[3]};
    c = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb = c[7] ^ bits[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic bit ref_hec_ok();
    return !HEC_CHK || (cell_b[4] == (ref_crc() ^ 8'h55));
  endfunction

  // Header bytes b0..b4 concatenate exactly to {GFC,VPI,VCI,CLP,PT,HEC}.
  function automatic logic [423:0] ref_cell();
    logic [423:0] c;
    c[423:384] = {cell_b[0], cell_b[1], cell_b[2], cell_b[3], cell_b[4]};
    for (int k = 0; k < 48; k++) c[8*k +: 8] = cell_b[5+k];
    return c;
  endfunction

  task automatic expect_cell();
    if (ref_hec_ok()) exp_q.push_back(ref_cell());
    else hec_exp++;
  endtask

  task automatic fill_random(input bit good_hec);
    for (int i = 0; i < 53; i++) cell_b[i] = 8'($urandom);
    if (good_hec || $urandom_range(0, 3) != 0) cell_b[4] = ref_crc() ^ 8'h55;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_byte(input logic s, input logic [7:0] d);
    soc = s; data = d; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; soc = 1'b0;
  endtask

  task automatic wait_clav();
    int k = 0;
    while (!clav && k < 1000) begin @(negedge clk); k++; end
    if (!clav) begin
      n_vec++; n_err++;
      $display("FAIL clav_timeout: clav stayed 0 for %0d cycles", k);
    end
  endtask

  // gap_mode: 0 none, 1 three idle cycles after every 7 bytes, 2 random idles
  task automatic send_cell(input int nbytes, input int gap_mode, input bit wait_cl);
    if (wait_cl) wait_clav();
    for (int i = 0; i < nbytes; i++) begin
      if (gap_mode == 1 && i > 0 && (i % 7) == 0) begin repeat (3) @(posedge clk); #1; end
      if (gap_mode == 2 && $urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      drive_byte(i == 0, cell_b[i]);
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin @(negedge clk); k++; end
    check("drain_pending", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_latency(input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (!rx_valid && k < 20);
    check(name, k, 2);
  endtask

  // ---------------- rx_ready generator ----------------
  initial forever begin
    @(posedge clk); #2;
    case (ready_mode)
      0: rx_ready = 1'b0;
      1: rx_ready = 1'b1;
      default: rx_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [423:0] e;
    forever begin
      @(negedge clk);
      if (runt_err) runt_seen++;
      if (hec_err) hec_seen++;
      if (!rst && rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_cell: got vci %0h with no expected cell", uni_VCI);
        end else begin
          e = exp_q.pop_front();
          check("cell_header", {uni_GFC, uni_VPI, uni_VCI, uni_CLP, uni_PT, uni_HEC}, e[423:384]);
          check("cell_payload", uni_Payload, e[383:0]);
        end
      end
    end
  end

  initial begin
    #3000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int runt_base, hec_base, hexp_base, runt_want;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_clav", clav, 0);
    check("reset_valid", rx_valid, 0);
    check("reset_full", fifo_full, 0);
    check("reset_pulses", {runt_err, hec_err}, 0);
    check("reset_uni", {uni_GFC, uni_VPI, uni_VCI, uni_CLP, uni_PT, uni_HEC, uni_Payload}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("clav_after_reset", clav, 1);

    // Directed single cell with known fields.
    ready_mode = 1;
    cell_b[0] = 8'hA5; cell_b[1] = 8'hC1; cell_b[2] = 8'h23; cell_b[3] = 8'h4A; cell_b[4] = 8'h00;
    for (int k = 0; k < 48; k++) cell_b[5+k] = 8'(k);
    if (!ref_hec_ok()) cell_b[4] = ref_crc() ^ 8'h55;
    expect_cell();
    send_cell(53, 0, 1);
    check_latency("latency_single");
    check("single_vci", uni_VCI, 16'h1234);
    check("single_vpi_gfc", {uni_GFC, uni_VPI, uni_CLP, uni_PT}, {4'hA, 8'h5C, 1'b1, 3'b010});
    check("payload_byte47", uni_Payload[383:376], 8'h2F);
    wait_drain();

    // Gapped cell: en low 3 cycles after every 7 bytes.
    fill_random(1'b1);
    expect_cell();
    send_cell(53, 1, 1);
    check_latency("latency_gapped");
    wait_drain();

    // Fill the FIFO with rx_ready low; the fifth cell waits in COMMIT.
    ready_mode = 0;
    for (int c = 0; c < 4; c++) begin
      fill_random(1'b1); expect_cell(); send_cell(53, 0, 1);
    end
    repeat (4) @(posedge clk); #1;
    check("full_after4", fifo_full, 1);
    check("clav_full", clav, 0);
    fill_random(1'b1); expect_cell(); send_cell(53, 0, 0);
    repeat (4) @(posedge clk); #1;
    check("clav_held", clav, 0);
    check("full_held", fifo_full, 1);
    check("valid_held", rx_valid, 1);
    ready_mode = 1;
    @(posedge clk); #1;
    ready_mode = 0;
    repeat (4) @(posedge clk); #1;
    check("full_after_pop_refill", fifo_full, 1);
    check("queued_after_pop", exp_q.size(), 4);
    ready_mode = 1;
    wait_drain();
    check("drained_full", fifo_full, 0);
    check("drained_clav", clav, 1);
    check("drained_valid", rx_valid, 0);

    // Mid-cell soc at payload byte 20 aborts the partial cell.
    runt_base = runt_seen;
    fill_random(1'b1);
    send_cell(25, 0, 1);
    fill_random(1'b1); expect_cell(); send_cell(53, 0, 0);
    wait_drain();
    check("runt_pulses", runt_seen - runt_base, 1);

    // HEC vectors: accepted/dropped according to whether checking is built in.
    hec_base = hec_seen; hexp_base = hec_exp; runt_base = runt_seen;
    for (int v = 0; v < 3; v++) begin
      fill_random(1'b1);
      cell_b[0] = 8'h00; cell_b[1] = 8'h00; cell_b[2] = 8'h00;
      cell_b[3] = (v == 2) ? 8'h00 : 8'h01;
      cell_b[4] = (v == 0) ? 8'h52 : ((v == 1) ? 8'h53 : 8'h55);
      expect_cell();
      send_cell(53, 0, 1);
      repeat (3) @(posedge clk); #1;
    end
    wait_drain();
    check("hec_pulses", hec_seen - hec_base, hec_exp - hexp_base);
    check("hec_no_runt", runt_seen - runt_base, 0);

    // Reset mid-cell with two cells buffered.
    ready_mode = 0;
    for (int c = 0; c < 2; c++) begin
      fill_random(1'b1); expect_cell(); send_cell(53, 0, 1);
    end
    fill_random(1'b1);
    send_cell(35, 0, 1);
    check("pre_reset_valid", rx_valid, 1);
    runt_base = runt_seen;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_reset_valid", rx_valid, 0);
    check("post_reset_full", fifo_full, 0);
    check("post_reset_clav", clav, 0);
    ready_mode = 1;
    fill_random(1'b1); expect_cell(); send_cell(53, 0, 1);
    wait_drain();
    check("post_reset_no_runt", runt_seen - runt_base, 0);

    // Randomized cells with random gaps, back-pressure, truncation and HEC errors.
    ready_mode = 2;
    runt_base = runt_seen; hec_base = hec_seen; hexp_base = hec_exp; runt_want = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 39 && $urandom_range(0, 7) == 0) begin
        fill_random(1'b1);
        send_cell($urandom_range(1, 52), 2, 1);
        runt_want++;
      end else begin
        fill_random(1'b0);
        expect_cell();
        send_cell(53, 2, 1);
      end
    end
    wait_drain();
    check("rand_runt_pulses", runt_seen - runt_base, runt_want);
    check("rand_hec_pulses", hec_seen - hec_base, hec_exp - hexp_base);

    ready_mode = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("final_valid", rx_valid, 0);
    check("final_full", fifo_full, 0);
    check("final_clav", clav, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
